// File: rtl/fir_mac_ctrl.sv
// Sequential single-MAC FIR: one accepted sample triggers LENGTH multiply-accumulates against a
// registered-read coefficient memory, then presents one filtered result.
module fir_mac_ctrl #(
    parameter int WIDTH     = 16,
    parameter int LENGTH    = 64,
    parameter int ACC_WIDTH = 2 * WIDTH + $clog2(LENGTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [$clog2(LENGTH):0]    coeff_addr,
    input  logic [WIDTH-1:0]           coeff_data,
    output logic [ACC_WIDTH-1:0]       out_data,
    output logic                       out_valid
);

    localparam int AW = $clog2(LENGTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          k_q, k_d;
    logic [AW-1:0]          wp_q, wp_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
    logic [WIDTH-1:0]       hist_q [LENGTH];
    logic                   hist_we;
    logic [AW-1:0]          rd_idx;
    logic signed [2*WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]   prod_ext;
    int                     idx;

    // x_q lags the issued address by one cycle, matching the memory's read latency.
    assign prod     = x_q * $signed(coeff_data);
    assign prod_ext = ACC_WIDTH'(prod);
    assign out_data = out_data_q;

    always_comb begin
        idx = int'(wp_q) - int'(k_q);
        if (idx < 0) begin
            idx = idx + LENGTH;
        end
        rd_idx = AW'(idx);
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        wp_d       = wp_q;
        x_d        = x_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        hist_we    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        coeff_addr = '0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hist_we = 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                coeff_addr = {1'b0, k_q};
                x_d        = hist_q[rd_idx];
                if (k_q != '0) begin
                    acc_d = acc_q + prod_ext;
                end
                if (k_q == AW'(LENGTH - 1)) begin
                    state_d = StDrain;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            StDrain: begin
                coeff_addr = {1'b0, k_q};
                acc_d      = acc_q + prod_ext;
                out_data_d = acc_q + prod_ext;
                state_d    = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                wp_d      = (wp_q == AW'(LENGTH - 1)) ? '0 : wp_q + AW'(1);
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            k_q        <= '0;
            wp_q       <= '0;
            x_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            wp_q       <= wp_d;
            x_q        <= x_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    // Cleared on reset so taps older than the first sample read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LENGTH; i++) begin
                hist_q[i] <= '0;
            end
        end else if (hist_we) begin
            hist_q[wp_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Randomized bench for fir_mac_ctrl: acceptances feed a queue-based FIR reference, and a separate
// monitor checks each output pulse's value and latency against it.
module tb_fir_mac_ctrl;

    localparam int W    = 16;
    localparam int L    = 64;
    localparam int AW   = 6;
    localparam int AccW = 38;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    in_data;
    logic            in_valid;
    logic            in_ready;
    logic [AW:0]     coeff_addr;
    logic [W-1:0]    coeff_data;
    logic [AccW-1:0] out_data;
    logic            out_valid;

    fir_mac_ctrl #(
        .WIDTH  (W),
        .LENGTH (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .coeff_addr (coeff_addr),
        .coeff_data (coeff_data),
        .out_data   (out_data),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    // Coefficient memory with one-cycle registered read.
    logic [W-1:0] coeff_mem [L];
    always @(posedge clk) coeff_data <= coeff_mem[coeff_addr[AW-1:0]];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    longint samples[$];
    longint exp_q[$];
    int     acc_cyc_q[$];
    bit     active = 0;
    int     active_c = 0;
    bit     tp_mode = 0;
    bit     have_last = 0;
    int     last_acc = 0;
    int     j_a;
    longint e_o;
    int     c_o;
    longint last_out = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: y[n] = sum over k of c[k] * x[n-k], with x before the first sample taken as 0.
    function automatic longint ref_y();
        longint s = 0;
        for (int k = 0; k < L && k < samples.size(); k++) begin
            s += longint'($signed(coeff_mem[k])) * samples[samples.size() - 1 - k];
        end
        return s;
    endfunction

    // Acceptance and address monitor. Inputs change 1 time unit after posedge, so they are
    // stable here and an in_valid & in_ready seen now is accepted at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (active) begin
                j_a = cyc - active_c;
                if (j_a >= 1 && j_a <= L) check("coeff_addr", longint'(coeff_addr), j_a - 1);
                if (j_a >= L) active = 0;
            end
            if (in_valid && in_ready) begin
                samples.push_back(longint'($signed(in_data)));
                exp_q.push_back(ref_y());
                acc_cyc_q.push_back(cyc);
                if (tp_mode && have_last) check("accept_gap", cyc - last_acc, L + 3);
                last_acc  = cyc;
                have_last = 1;
                active    = 1;
                active_c  = cyc;
            end
        end
    end

    // Output monitor.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL out_valid: pulse with out_data=%0d, expected no output pending",
                         longint'($signed(out_data)));
            end else begin
                e_o = exp_q.pop_front();
                c_o = acc_cyc_q.pop_front();
                last_out = longint'($signed(out_data));
                check("out_data", last_out, e_o);
                check("out_latency", cyc - c_o, L + 2);
            end
        end
    end

    task automatic flush();
        samples.delete();
        exp_q.delete();
        acc_cyc_q.delete();
        active    = 0;
        have_last = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] x);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d outputs pending, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic set_ramp_coeffs();
        for (int k = 0; k < L; k++) coeff_mem[k] = W'(k + 1);
    endtask

    task automatic set_const_coeffs(input logic [W-1:0] c);
        for (int k = 0; k < L; k++) coeff_mem[k] = c;
    endtask

    task automatic set_rand_coeffs();
        for (int k = 0; k < L; k++) coeff_mem[k] = W'($urandom);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        set_ramp_coeffs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_coeff_addr", longint'(coeff_addr), 0);
        rst = 1'b0;

        // Impulse
        send(W'(1));
        for (int i = 0; i < 70; i++) send('0);
        wait_done();
        check("impulse_tail", last_out, 0);

        // Step
        pulse_reset();
        set_const_coeffs(W'(1));
        for (int i = 0; i < 65; i++) send(W'(100));
        wait_done();
        check("step_final", last_out, 6400);

        // Signed extremes
        pulse_reset();
        set_const_coeffs(16'h8000);
        for (int i = 0; i < 64; i++) send(16'h8000);
        wait_done();
        check("extreme_final", last_out, 64'sd68719476736);
        pulse_reset();
        set_rand_coeffs();
        coeff_mem[0] = 16'h8000;
        send(16'h7fff);
        wait_done();
        check("extreme_single", last_out, -64'sd1073709056);

        // Throughput with in_valid held high
        pulse_reset();
        set_rand_coeffs();
        tp_mode = 1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = W'($urandom);
        repeat (300) begin
            @(posedge clk);
            #1;
            in_data = in_data + W'(1);
        end
        in_valid = 1'b0;
        tp_mode  = 0;
        wait_done();

        // Reset mid-RUN
        pulse_reset();
        set_ramp_coeffs();
        send(W'(1));
        n = 0;
        while (coeff_addr != 7'd30 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midrun_reached_k30", longint'(coeff_addr), 30);
        #1;
        rst = 1'b1;
        flush();
        #1;
        check("midrun_in_ready", longint'(in_ready), 1);
        check("midrun_out_valid", longint'(out_valid), 0);
        check("midrun_out_data", longint'(out_data), 0);
        check("midrun_coeff_addr", longint'(coeff_addr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(W'(1));
        for (int i = 0; i < 65; i++) send('0);
        wait_done();
        check("midrun_impulse_tail", last_out, 0);

        // Wrap with random samples and gaps
        pulse_reset();
        set_rand_coeffs();
        for (int i = 0; i < 130; i++) begin
            send(W'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_done();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
